decode_stage: RTL

//   Registered MIPS instruction-decode stage between fetch and execute. Splits a
//   32-bit instruction into its R/I/J fields, classifies the type, extends the

---
 rtl/decode_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// MIPS decode stage: splits instruction fields, classifies type, extends the
// immediate and computes branch/jump targets behind a one-entry handshake register.
module decode_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       shamt,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [25:0]      address,
    output logic [1:0]       ins_type,
    output logic [31:0]      imm_ext,
    output logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  jump_target,
    output logic [CNT_W-1:0] decoded_count
);

    logic            w_accept;
    logic [5:0]      w_op;
    logic [1:0]      w_type;
    logic [31:0]     w_imm;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_boff;
    logic [PC_W-1:0] w_btgt;
    logic [PC_W-1:0] w_jtgt;

    assign in_ready = !reset && !flush && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_op     = in_ins[31:26];

    // Branch offset is always sign-extended, independent of the imm_ext rule.
    assign w_pc4  = in_pc + PC_W'(3'd4);
    assign w_boff = PC_W'({{14{in_ins[15]}}, in_ins[15:0], 2'b00});
    assign w_btgt = w_pc4 + w_boff;

    generate
        if (PC_W == 28) begin : g_jt28
            assign w_jtgt = {in_ins[25:0], 2'b00};
        end else begin : g_jtn
            assign w_jtgt = {w_pc4[PC_W-1:28], in_ins[25:0], 2'b00};
        end
    endgenerate

    always_comb begin
        w_type = 2'd1;
        unique case (w_op)
            6'h00:        w_type = 2'd0;
            6'h02, 6'h03: w_type = 2'd2;
            6'h3F:        w_type = 2'd3;
            default:      w_type = 2'd1;
        endcase
    end

    always_comb begin
        w_imm = {{16{in_ins[15]}}, in_ins[15:0]};
        unique case (w_op)
            6'h0C, 6'h0D, 6'h0E: w_imm = {16'h0000, in_ins[15:0]};
            6'h0F:               w_imm = {in_ins[15:0], 16'h0000};
            default:             w_imm = {{16{in_ins[15]}}, in_ins[15:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            opcode        <= '0;
            funct         <= '0;
            shamt         <= '0;
            rs            <= '0;
            rt            <= '0;
            rd            <= '0;
            address       <= '0;
            ins_type      <= '0;
            imm_ext       <= '0;
            branch_target <= '0;
            jump_target   <= '0;
            decoded_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            opcode        <= w_op;
            funct         <= in_ins[5:0];
            shamt         <= in_ins[10:6];
            rs            <= in_ins[25:21];
            rt            <= in_ins[20:16];
            rd            <= in_ins[15:11];
            address       <= in_ins[25:0];
            ins_type      <= w_type;
            imm_ext       <= w_imm;
            branch_target <= w_btgt;
            jump_target   <= w_jtgt;
            decoded_count <= decoded_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
